// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - parametrised register file with busy scoreboard and post-reset clear sweep (option: REGFILE_BYPASS_EN)
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 6,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rstn,
    output logic                       init_done,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       claim_en,
    input  logic [ADDR_W-1:0]          claim_addr,
    output logic [ADDR_W:0]            busy_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   clr_ptr;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]    busy;

    logic run;
    logic wr_ok;
    logic claim_ok;
    logic cnt_inc;
    logic cnt_dec;

    assign run = (state == ST_RUN);

    // Qualify write/claim (RUN only, entry 0 inert when hardwired) and derive busy population deltas
    always_comb begin
        wr_ok    = run && we && !((ZERO_REG != 0) && (wr_addr == '0));
        claim_ok = run && claim_en && !((ZERO_REG != 0) && (claim_addr == '0));
        // Only a genuine 0->1 or 1->0 transition moves the count; a claim on the written entry keeps it busy
        cnt_inc  = claim_ok && !busy[claim_addr];
        cnt_dec  = wr_ok && busy[wr_addr] && !(claim_ok && (claim_addr == wr_addr));
    end

    // Control state: sweep pointer, mode, scoreboard bits and their population count
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= ST_CLEAR;
            clr_ptr   <= '0;
            busy      <= '0;
            busy_cnt  <= '0;
            init_done <= 1'b0;
        end else if (state == ST_CLEAR) begin
            clr_ptr <= clr_ptr + ADDR_W'(1);
            if (clr_ptr == {ADDR_W{1'b1}}) begin
                state     <= ST_RUN;
                init_done <= 1'b1;
            end
        end else begin
            // Claim is applied after the write so a same-entry claim leaves the entry busy
            if (wr_ok)
                busy[wr_addr] <= 1'b0;
            if (claim_ok)
                busy[claim_addr] <= 1'b1;
            if (cnt_inc && !cnt_dec)
                busy_cnt <= busy_cnt + (ADDR_W+1)'(1);
            else if (cnt_dec && !cnt_inc)
                busy_cnt <= busy_cnt - (ADDR_W+1)'(1);
        end
    end

    // Storage: zeroed one entry per cycle during the sweep, then written from writeback
    always_ff @(posedge clk) begin
        if (rstn) begin
            if (!run)
                mem[clr_ptr] <= '0;
            else if (wr_ok)
                mem[wr_addr] <= wr_data;
        end
    end

    // Asynchronous read ports; everything reads 0/idle until the sweep has finished
    always_comb begin
        logic [ADDR_W-1:0] ra;
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra = rd_addr[i*ADDR_W +: ADDR_W];
            if (run && !((ZERO_REG != 0) && (ra == '0))) begin
                rd_data[i*DATA_W +: DATA_W] = mem[ra];
                rd_busy[i]                  = busy[ra];
`ifdef REGFILE_BYPASS_EN
                if (wr_ok && (ra == wr_addr)) begin
                    rd_data[i*DATA_W +: DATA_W] = wr_data;
                    rd_busy[i]                  = claim_ok && (claim_addr == wr_addr);
                end
`else
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb
module tb_regfile_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 64;

    logic                     clk = 1'b0;
    logic                     rstn;
    logic                     init_done;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     we;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     claim_en;
    logic [ADDR_W-1:0]        claim_addr;
    logic [ADDR_W:0]          busy_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_sb #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rstn(rstn), .init_done(init_done),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; claim_en = 1'b0;
    endtask

    // Counts cycles from release until init_done rises, sampling once per cycle
    task automatic wait_init(input string tag);
        int cyc;
        cyc = 0;
        while (!init_done && cyc < 200) begin
            cyc++;
            step();
        end
        check(tag, 64'(cyc), 64'd64);
    endtask

    task automatic check_all_zero(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = {ADDR_W'(a), ADDR_W'(a)};
            #1;
            check($sformatf("%s_data%0d", tag, a), 64'(rd_data), 64'd0);
            check($sformatf("%s_busy%0d", tag, a), 64'(rd_busy), 64'd0);
        end
    endtask

    initial begin
        rstn = 1'b0; idle(); wr_addr = '0; wr_data = '0; claim_addr = '0; rd_addr = '0;
        step(); step();
        check("rst_init_done", 64'(init_done), 64'd0);
        check("rst_busy_cnt", 64'(busy_cnt), 64'd0);

        // Release; try to write and claim during the sweep, both must be ignored
        rstn = 1'b1;
        we = 1'b1; wr_addr = 6'd5; wr_data = 32'hdead; claim_en = 1'b1; claim_addr = 6'd5;
        rd_addr = {6'd5, 6'd5};
        #1;
        check("clear_rd_data", 64'(rd_data), 64'd0);
        check("clear_rd_busy", 64'(rd_busy), 64'd0);
        #1;
        idle();
        wait_init("sweep_len");
        check("sweep_busy_cnt", 64'(busy_cnt), 64'd0);
        check_all_zero("sweep");

        // Write/read
        we = 1'b1; wr_addr = 6'd1; wr_data = 32'd32; step();
        wr_addr = 6'd5; wr_data = 32'd21; step();
        idle(); rd_addr = {6'd5, 6'd1}; #1;
        check("wr_rd_pair", 64'(rd_data), {32'd21, 32'd32});
        we = 1'b1; wr_addr = 6'd0; wr_data = 32'd200; claim_en = 1'b1; claim_addr = 6'd0; step();
        idle(); rd_addr = {6'd0, 6'd0}; #1;
        check("zero_reg_data", 64'(rd_data), 64'd0);
        check("zero_reg_busy", 64'(rd_busy), 64'd0);
        check("zero_reg_cnt", 64'(busy_cnt), 64'd0);

        // Scoreboard
        claim_en = 1'b1; claim_addr = 6'd3; step();
        claim_addr = 6'd7; step();
        idle(); rd_addr = {6'd7, 6'd3}; #1;
        check("sb_cnt2", 64'(busy_cnt), 64'd2);
        check("sb_busy37", 64'(rd_busy), 64'b11);
        we = 1'b1; wr_addr = 6'd3; wr_data = 32'd33; step();
        idle(); #1;
        check("sb_cnt1", 64'(busy_cnt), 64'd1);
        check("sb_busy_after_wr", 64'(rd_busy), 64'b10);
        we = 1'b1; wr_addr = 6'd7; wr_data = 32'd77; claim_en = 1'b1; claim_addr = 6'd7; step();
        idle(); #1;
        check("sb_same_cnt", 64'(busy_cnt), 64'd1);
        check("sb_same_busy", 64'(rd_busy), 64'b10);
        check("sb_same_data", 64'(rd_data), {32'd77, 32'd33});
        // Claim 9 while writing busy 7: both transition, net count unchanged
        we = 1'b1; wr_addr = 6'd7; wr_data = 32'd78; claim_en = 1'b1; claim_addr = 6'd9; step();
        idle(); rd_addr = {6'd9, 6'd7}; #1;
        check("sb_split_cnt", 64'(busy_cnt), 64'd1);
        check("sb_split_busy", 64'(rd_busy), 64'b10);

        // Same-cycle read/write
        rd_addr = {6'd1, 6'd1}; we = 1'b1; wr_addr = 6'd1; wr_data = 32'd200; #1;
`ifdef REGFILE_BYPASS_EN
        check("rw_same_data", 64'(rd_data[31:0]), 64'd200);
`else
        check("rw_same_data", 64'(rd_data[31:0]), 64'd32);
`endif
        check("rw_same_busy", 64'(rd_busy), 64'd0);
        step(); idle(); #1;
        check("rw_after_data", 64'(rd_data[31:0]), 64'd200);
        rd_addr = {6'd2, 6'd2}; we = 1'b1; wr_addr = 6'd2; wr_data = 32'd55;
        claim_en = 1'b1; claim_addr = 6'd2; #1;
`ifdef REGFILE_BYPASS_EN
        check("rwc_same_data", 64'(rd_data[31:0]), 64'd55);
        check("rwc_same_busy", 64'(rd_busy), 64'b11);
`else
        check("rwc_same_data", 64'(rd_data[31:0]), 64'd0);
        check("rwc_same_busy", 64'(rd_busy), 64'b00);
`endif
        step(); idle(); #1;
        check("rwc_after_busy", 64'(rd_busy), 64'b11);
        check("rwc_after_cnt", 64'(busy_cnt), 64'd2);

        // Mid-operation reset
        rstn = 1'b0; step();
        check("mid_rst_cnt", 64'(busy_cnt), 64'd0);
        check("mid_rst_init", 64'(init_done), 64'd0);
        rd_addr = {6'd5, 6'd1}; #1;
        check("mid_rst_rd", 64'(rd_data), 64'd0);
        rstn = 1'b1;
        wait_init("resweep_len");
        check_all_zero("resweep");

        // Counter saturation
        claim_en = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            claim_addr = ADDR_W'(a); step();
        end
        idle(); rd_addr = {6'd0, 6'd63}; #1;
        check("sat_cnt63", 64'(busy_cnt), 64'd63);
        check("sat_busy", 64'(rd_busy), 64'b01);
        claim_en = 1'b1; claim_addr = 6'd10; step();
        idle(); #1;
        check("sat_reclaim", 64'(busy_cnt), 64'd63);
        we = 1'b1;
        for (int a = 1; a < DEPTH; a++) begin
            wr_addr = ADDR_W'(a); wr_data = 32'(a); step();
        end
        idle(); rd_addr = {6'd63, 6'd10}; #1;
        check("sat_drain", 64'(busy_cnt), 64'd0);
        check("sat_drain_data", 64'(rd_data), {32'd63, 32'd10});
        check("sat_drain_busy", 64'(rd_busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
